// File: rtl/pd_loop_sequencer_if.sv
// Bundle of command, sensor, PD-stage and duty signals around pd_loop_sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding system's.
interface pd_loop_sequencer_if;
    logic       cmd_valid;
    logic       cmd_sel;
    logic [7:0] cmd_data;
    logic       speed_valid;
    logic [8:0] speed_meas;
    logic       pd_en;
    logic [7:0] pd_target;
    logic [8:0] pd_current;
    logic [7:0] pd_gains;
    logic [7:0] pd_out;
    logic [7:0] duty;
    logic       duty_valid;
    logic       busy;
    logic       overrun;

    modport slave (
        input  cmd_valid, cmd_sel, cmd_data, speed_valid, speed_meas, pd_out,
        output pd_en, pd_target, pd_current, pd_gains, duty, duty_valid, busy, overrun
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_data, speed_valid, speed_meas, pd_out,
        input  pd_en, pd_target, pd_current, pd_gains, duty, duty_valid, busy, overrun
    );
endinterface

// File: rtl/pd_loop_sequencer.sv
// Control-loop sequencer: snapshots command/speed on each prescaler tick, runs the PD stage and
// latches its result as the PWM duty. Define DUTY_SLEW_EN to rate-limit duty changes to +/-SLEW.
module pd_loop_sequencer #(
    parameter int unsigned LOOP_DIV = 50000,
    parameter int unsigned PD_LAT   = 2,
    parameter int unsigned SLEW     = 4
) (
    input logic                CLK,
    input logic                RST,
    pd_loop_sequencer_if.slave seq_if
);

    localparam int unsigned CntW = $clog2(LOOP_DIV);

    typedef enum logic [1:0] {StIdle, StRun, StCapture} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] div_q, div_d;
    logic [3:0]      lat_q, lat_d;
    logic            fresh_q, fresh_d;
    logic [7:0]      tgt_stg_q, tgt_stg_d;
    logic [7:0]      gain_stg_q, gain_stg_d;
    logic [8:0]      spd_stg_q, spd_stg_d;
    logic [7:0]      pd_target_q, pd_target_d;
    logic [8:0]      pd_current_q, pd_current_d;
    logic [7:0]      pd_gains_q, pd_gains_d;
    logic [7:0]      duty_q, duty_d;
    logic            duty_valid_q, duty_valid_d;
    logic            overrun_q, overrun_d;

    logic       tick;
    logic       load;
    logic       stale;
    logic [7:0] duty_next;

    assign tick  = (div_q == CntW'(LOOP_DIV - 1));
    assign load  = (state_q == StIdle) && tick && fresh_q;
    assign stale = (state_q == StIdle) && tick && !fresh_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            div_q        <= '0;
            lat_q        <= '0;
            fresh_q      <= 1'b0;
            tgt_stg_q    <= '0;
            gain_stg_q   <= '0;
            spd_stg_q    <= '0;
            pd_target_q  <= '0;
            pd_current_q <= '0;
            pd_gains_q   <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            lat_q        <= lat_d;
            fresh_q      <= fresh_d;
            tgt_stg_q    <= tgt_stg_d;
            gain_stg_q   <= gain_stg_d;
            spd_stg_q    <= spd_stg_d;
            pd_target_q  <= pd_target_d;
            pd_current_q <= pd_current_d;
            pd_gains_q   <= pd_gains_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StRun;
                    lat_d   = '0;
                end
            end
            StRun: begin
                lat_d = lat_q + 4'd1;
                if (lat_q == 4'(PD_LAT - 1)) begin
                    state_d = StCapture;
                end
            end
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    `ifdef DUTY_SLEW_EN
    localparam logic signed [8:0] SlewLim = 9'(SLEW);

    logic signed [8:0] slew_diff;
    logic signed [8:0] slew_step;

    always_comb begin
        slew_diff = $signed({1'b0, seq_if.pd_out}) - $signed({1'b0, duty_q});
        if (slew_diff > SlewLim) begin
            slew_step = SlewLim;
        end else if (slew_diff < -SlewLim) begin
            slew_step = -SlewLim;
        end else begin
            slew_step = slew_diff;
        end
        // Clamped step always lands between duty_q and pd_out, so 8-bit wrap is safe.
        duty_next = duty_q + 8'(slew_step);
    end
    `else
    logic [31:0] unused_slew;
    assign unused_slew = SLEW;
    assign duty_next   = seq_if.pd_out;
    `endif

    always_comb begin
        div_d        = tick ? '0 : div_q + CntW'(1);
        tgt_stg_d    = tgt_stg_q;
        gain_stg_d   = gain_stg_q;
        spd_stg_d    = spd_stg_q;
        fresh_d      = fresh_q;
        pd_target_d  = pd_target_q;
        pd_current_d = pd_current_q;
        pd_gains_d   = pd_gains_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        overrun_d    = overrun_q | (tick && (state_q != StIdle));

        if (seq_if.cmd_valid) begin
            if (seq_if.cmd_sel) begin
                gain_stg_d = seq_if.cmd_data;
            end else begin
                tgt_stg_d = seq_if.cmd_data;
            end
        end

        // Snapshot uses the pre-edge staging values; a same-edge sample keeps fresh set.
        if (load) begin
            pd_target_d  = tgt_stg_q;
            pd_current_d = spd_stg_q;
            pd_gains_d   = gain_stg_q;
            fresh_d      = 1'b0;
        end
        if (seq_if.speed_valid) begin
            spd_stg_d = seq_if.speed_meas;
            fresh_d   = 1'b1;
        end

        if (stale) begin
            duty_d       = '0;
            duty_valid_d = 1'b1;
        end else if (state_q == StCapture) begin
            duty_d       = duty_next;
            duty_valid_d = 1'b1;
        end
    end

    always_comb begin
        seq_if.pd_en      = (state_q == StRun);
        seq_if.busy       = (state_q != StIdle);
        seq_if.pd_target  = pd_target_q;
        seq_if.pd_current = pd_current_q;
        seq_if.pd_gains   = pd_gains_q;
        seq_if.duty       = duty_q;
        seq_if.duty_valid = duty_valid_q;
        seq_if.overrun    = overrun_q;
    end

endmodule

// File: tb/tb_pd_loop_sequencer.sv
// Scoreboard bench for pd_loop_sequencer: a main loop sequencer (LOOP_DIV=20, PD_LAT=2) and a
// second instance (LOOP_DIV=8, PD_LAT=15) that is forced to overrun.
module tb_pd_loop_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pd_loop_sequencer_if ifa();
    pd_loop_sequencer_if ifb();

    pd_loop_sequencer #(.LOOP_DIV(20), .PD_LAT(2), .SLEW(4)) u_dut (
        .CLK    (clk),
        .RST    (rst),
        .seq_if (ifa)
    );

    pd_loop_sequencer #(.LOOP_DIV(8), .PD_LAT(15), .SLEW(4)) u_dut_ovr (
        .CLK    (clk),
        .RST    (rst),
        .seq_if (ifb)
    );

    `ifdef DUTY_SLEW_EN
    localparam int D1 = 4;
    localparam int D2 = 8;
    localparam int D3 = 12;
    localparam int DB = 4;
    `else
    localparam int D1 = 200;
    localparam int D2 = 200;
    localparam int D3 = 200;
    localparam int DB = 33;
    `endif

    typedef struct {
        logic [7:0] tgt;
        logic [8:0] cur;
        logic [7:0] gains;
    } snap_t;

    typedef struct {
        logic [7:0] duty;
        int         cyc;
    } duty_t;

    snap_t snap_q[$];
    duty_t duty_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    cyc        = 0;
    logic  rst_seen   = 1'b1;

    // Bench-side cycle count mirrors where the prescaler should be after reset.
    always @(posedge clk) begin
        rst_seen <= rst;
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (cyc != k && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != k) check("wait_cyc_timeout", cyc, k);
    endtask

    task automatic drive_a(input int k, input logic cv, input logic sel, input logic [7:0] d,
                           input logic sv, input logic [8:0] s);
        wait_cyc(k);
        ifa.cmd_valid   = cv;
        ifa.cmd_sel     = sel;
        ifa.cmd_data    = d;
        ifa.speed_valid = sv;
        ifa.speed_meas  = s;
        @(negedge clk);
        ifa.cmd_valid   = 1'b0;
        ifa.speed_valid = 1'b0;
    endtask

    task automatic push_loop(input logic [7:0] t, input logic [8:0] c, input logic [7:0] g,
                             input int d, input int tick_cyc);
        snap_t s;
        duty_t e;
        s.tgt   = t;
        s.cur   = c;
        s.gains = g;
        e.duty  = 8'(d);
        e.cyc   = tick_cyc + 4;
        snap_q.push_back(s);
        duty_q.push_back(e);
    endtask

    task automatic push_stale(input int tick_cyc);
        duty_t e;
        e.duty = 8'd0;
        e.cyc  = tick_cyc + 1;
        duty_q.push_back(e);
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_pd_en"}, ifa.pd_en, 0);
        check({tag, "_pd_target"}, ifa.pd_target, 0);
        check({tag, "_pd_current"}, ifa.pd_current, 0);
        check({tag, "_pd_gains"}, ifa.pd_gains, 0);
        check({tag, "_duty"}, ifa.duty, 0);
        check({tag, "_duty_valid"}, ifa.duty_valid, 0);
        check({tag, "_busy"}, ifa.busy, 0);
        check({tag, "_overrun"}, ifa.overrun, 0);
    endtask

    // Monitor: pops snapshot expectations on pd_en rise and duty expectations on duty_valid.
    snap_t cur_snap;
    initial begin
        logic pd_en_prev = 1'b0;
        int   run_len    = 0;
        duty_t e;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                pd_en_prev = 1'b0;
                run_len    = 0;
            end else begin
                if (ifa.pd_en && !pd_en_prev) begin
                    if (snap_q.size() == 0) check("pd_en_unexpected", 1, 0);
                    else cur_snap = snap_q.pop_front();
                end
                if (ifa.pd_en) begin
                    run_len++;
                    check("pd_target", ifa.pd_target, cur_snap.tgt);
                    check("pd_current", ifa.pd_current, cur_snap.cur);
                    check("pd_gains", ifa.pd_gains, cur_snap.gains);
                end else if (pd_en_prev) begin
                    check("pd_en_len", run_len, 2);
                    run_len = 0;
                end
                if (ifa.duty_valid) begin
                    if (duty_q.size() == 0) begin
                        check("duty_valid_unexpected", 1, 0);
                    end else begin
                        e = duty_q.pop_front();
                        check("duty", ifa.duty, e.duty);
                        check("duty_valid_cycle", cyc, e.cyc);
                    end
                end
                pd_en_prev = ifa.pd_en;
            end
        end
    end

    task automatic seq_a();
        drive_a(2, 1'b1, 1'b0, 8'd80, 1'b0, 9'd0);
        drive_a(3, 1'b1, 1'b1, 8'hC6, 1'b0, 9'd0);
        drive_a(4, 1'b0, 1'b0, 8'd0, 1'b1, 9'd70);
        wait_cyc(19);
        push_loop(8'd80, 9'd70, 8'hC6, D1, 19);
        drive_a(20, 1'b1, 1'b0, 8'd90, 1'b0, 9'd0);
        drive_a(25, 1'b0, 1'b0, 8'd0, 1'b1, 9'd75);
        // Command and sample on the tick edge both land in staging for the next loop.
        wait_cyc(39);
        push_loop(8'd90, 9'd75, 8'hC6, D2, 39);
        drive_a(39, 1'b1, 1'b0, 8'd95, 1'b1, 9'd77);
        wait_cyc(59);
        push_loop(8'd95, 9'd77, 8'hC6, D3, 59);
        wait_cyc(79);
        push_stale(79);
        drive_a(85, 1'b0, 1'b0, 8'd0, 1'b1, 9'd60);
        wait_cyc(99);
        push_loop(8'd95, 9'd60, 8'hC6, D1, 99);
        drive_a(105, 1'b0, 1'b0, 8'd0, 1'b1, 9'd65);
        wait_cyc(119);
        snap_q.push_back('{tgt: 8'd95, cur: 9'd65, gains: 8'hC6});
        wait_cyc(120);
        check("run_before_rst", ifa.pd_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero_a("mid_run_rst");
        check("ovr_cleared_by_rst", ifb.overrun, 0);
        drive_a(5, 1'b0, 1'b0, 8'd0, 1'b1, 9'd50);
        wait_cyc(19);
        push_loop(8'd0, 9'd50, 8'd0, D1, 19);
        wait_cyc(30);
        check("snap_q_drained", snap_q.size(), 0);
        check("duty_q_drained", duty_q.size(), 0);
        check("a_overrun_clear", ifa.overrun, 0);
    endtask

    task automatic seq_b();
        wait_cyc(2);
        ifb.speed_meas  = 9'd40;
        ifb.speed_valid = 1'b1;
        @(negedge clk);
        ifb.speed_valid = 1'b0;
        wait_cyc(6);
        check("ovr_before", ifb.overrun, 0);
        wait_cyc(10);
        check("ovr_pd_en_run", ifb.pd_en, 1);
        check("ovr_busy_run", ifb.busy, 1);
        check("ovr_pd_current", ifb.pd_current, 40);
        wait_cyc(16);
        check("ovr_set", ifb.overrun, 1);
        wait_cyc(22);
        check("ovr_pd_en_last", ifb.pd_en, 1);
        wait_cyc(23);
        check("ovr_pd_en_capture", ifb.pd_en, 0);
        wait_cyc(24);
        check("ovr_duty_valid", ifb.duty_valid, 1);
        check("ovr_duty", ifb.duty, DB);
        wait_cyc(25);
        check("ovr_duty_valid_once", ifb.duty_valid, 0);
        wait_cyc(32);
        check("ovr_stale_valid", ifb.duty_valid, 1);
        check("ovr_stale_duty", ifb.duty, 0);
        check("ovr_stale_no_pd_en", ifb.pd_en, 0);
        wait_cyc(100);
        check("ovr_sticky", ifb.overrun, 1);
    endtask

    initial begin
        ifa.cmd_valid   = 1'b0;
        ifa.cmd_sel     = 1'b0;
        ifa.cmd_data    = 8'd0;
        ifa.speed_valid = 1'b0;
        ifa.speed_meas  = 9'd0;
        ifa.pd_out      = 8'd200;
        ifb.cmd_valid   = 1'b0;
        ifb.cmd_sel     = 1'b0;
        ifb.cmd_data    = 8'd0;
        ifb.speed_valid = 1'b0;
        ifb.speed_meas  = 9'd0;
        ifb.pd_out      = 8'd33;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero_a("reset");
        check("reset_b_overrun", ifb.overrun, 0);
        check("reset_b_busy", ifb.busy, 0);
        fork
            seq_a();
            seq_b();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pd_loop_sequencer.md
PD_LOOP_SEQUENCER -- requirements
Module: pd_loop_sequencer

Interface
REQ-001 Parameter LOOP_DIV, default 50000: CLK cycles between control-loop ticks (legal range 8..2^20).
REQ-002 Parameter PD_LAT, default 2: cycles from pd_en rising until pd_out is valid (legal range 1..15).
REQ-003 Parameter SLEW, default 4: maximum duty change per loop when DUTY_SLEW_EN is defined.
REQ-004 CLK  in  1  sole clock, all logic on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command byte strobe from the UART decoder, one cycle per byte.
REQ-007 cmd_sel  in  1  0 = target velocity byte, 1 = packed KpKd gain byte.
REQ-008 cmd_data  in  8  command payload.
REQ-009 speed_valid  in  1  one-cycle strobe for a new speed measurement.
REQ-010 speed_meas  in  9  measured velocity, unsigned.
REQ-011 pd_en  out  1  enable to the PD stage.
REQ-012 pd_target  out  8  target velocity to the PD stage.
REQ-013 pd_current  out  9  current velocity to the PD stage.
REQ-014 pd_gains  out  8  KpKd to the PD stage.
REQ-015 pd_out  in  8  PD stage result (out_vel).
REQ-016 duty  out  8  PWM duty command.
REQ-017 duty_valid  out  1  one-cycle strobe when duty is updated.
REQ-018 busy  out  1  high whenever the state is not IDLE.
REQ-019 overrun  out  1  sticky flag for a tick lost while busy; cleared only by RST.

Function
REQ-020 Prescaler counts 0..LOOP_DIV-1 and emits a one-cycle tick at terminal count, then wraps to 0.
REQ-021 cmd_valid writes cmd_data into staging register tgt_stg (cmd_sel=0) or gain_stg (cmd_sel=1) on the same edge, in any state.
REQ-022 speed_valid latches speed_meas into spd_stg and sets fresh=1.
REQ-023 States: IDLE, RUN, CAPTURE.
REQ-024 IDLE + tick + fresh=1: copy tgt_stg, gain_stg and spd_stg to pd_target, pd_gains and pd_current; clear fresh; go to RUN.
REQ-025 IDLE + tick + fresh=0 (stale sensor): duty <= 0 and duty_valid pulse next cycle; stay IDLE; pd_en remains low.
REQ-026 RUN: pd_en=1 for exactly PD_LAT cycles, counted from RUN entry; then go to CAPTURE.
REQ-027 CAPTURE: pd_en=0; duty <= pd_out, subject to REQ-036; duty_valid=1 for this one cycle; return to IDLE.
REQ-028 Tick-to-duty_valid latency is PD_LAT+2 cycles.
REQ-029 pd_target, pd_current and pd_gains are stable from RUN entry until the next loop; commands arriving mid-loop affect only the next loop.
REQ-030 cmd_valid on the same edge as the IDLE tick: the snapshot takes the old staging value and the new byte lands in staging.
REQ-031 speed_valid on the same edge as the tick: the snapshot takes the old spd_stg, and fresh ends at 1 because the new sample counts for the next loop.
REQ-032 Tick while busy: overrun <= 1, the tick is dropped and the current loop continues unaffected.

Reset
REQ-033 RST=1 forces: state IDLE; prescaler 0; fresh 0; all staging registers 0; pd_en, pd_target, pd_current, pd_gains, duty, duty_valid, busy and overrun all 0.
REQ-034 RST asserted mid-RUN aborts the loop: pd_en=0 on the next edge and no duty_valid is issued.
REQ-035 RST has priority over cmd_valid, speed_valid and tick on the same edge.

Configuration
REQ-036 Macro DUTY_SLEW_EN defined: each loop clamps the duty step to ±SLEW, i.e. duty_new = duty_old + clamp(pd_out - duty_old, -SLEW, +SLEW), with signed 9-bit difference. The stale-sensor zeroing of REQ-025 bypasses the clamp.
REQ-037 Macro DUTY_SLEW_EN undefined: duty_new = pd_out directly, and SLEW is unused.

Verification
REQ-038 Use LOOP_DIV=20 and PD_LAT=2. Send cmd target=80 and gains=0xC6, speed=70, then wait for a tick -> pd_target=80, pd_current=70, pd_gains=0xC6, pd_en high for 2 cycles, and duty_valid exactly 4 cycles after the tick.
REQ-039 Hold pd_out=200 and start from duty=0. With DUTY_SLEW_EN defined -> duty goes 4, 8, 12 on successive loops. Undefined -> duty=200 on the first loop.
REQ-040 Let a tick occur with no speed_valid since the previous loop -> duty=0, duty_valid pulses, pd_en never asserts.
REQ-041 Write target=90 during RUN -> pd_target stays 80 for this loop and shows 90 in the next loop.
REQ-042 Force a tick while in RUN (LOOP_DIV=8, PD_LAT=15) -> overrun=1 and stays 1 until RST, and the loop completes normally.
REQ-043 Assert RST for 1 cycle mid-RUN -> all outputs 0 on the next edge, no duty_valid, and the prescaler restarts from 0.
